// File: rtl/scaled_clk_monitor.sv
// Receive-side monitor for the scaled clock: synchronises it, strobes its edges,
// measures each half-period and tracks lock/loss against the expected ratio.
module scaled_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 9,
  parameter int EXP_HALF    = 101,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scaled_clk_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_count,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] HP_MIN = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HP_MAX = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TO_TH  = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [CNT_W-1:0] HP_SAT = '1;
  localparam int               GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, rise_q, fall_q;
  logic [CNT_W-1:0]       hp_cnt_q, hp_cnt_d, half_q, half_d;
  logic                   pv_q, pv_d;
  logic                   have_ref_q, have_ref_d;
  logic                   to_fired_q, to_fired_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic                   lost_q, lost_d;
  logic [7:0]             err_q, err_d;
  logic                   run, sync_lvl, rise_d, fall_d, edge_d, edge_q;
  logic                   timeout, in_range, go_lost;

  // Edge detection and timeout; the synchroniser keeps running in IDLE so
  // re-enabling never produces a stale edge.
  always_comb begin
    run      = enable && (state_q != ST_IDLE);
    sync_lvl = sync_q[SYNC_STAGES-1];
    rise_d   = run && sync_lvl && !prev_q;
    fall_d   = run && !sync_lvl && prev_q;
    edge_d   = rise_d || fall_d;
    edge_q   = rise_q || fall_q;
    timeout  = run && !edge_d && !to_fired_q && (hp_cnt_q == TO_TH);
    in_range = (half_q >= HP_MIN) && (half_q <= HP_MAX);
  end

  always_comb begin
    hp_cnt_d   = hp_cnt_q;
    half_d     = half_q;
    pv_d       = 1'b0;
    have_ref_d = have_ref_q;
    to_fired_d = to_fired_q;
    if (!run) begin
      hp_cnt_d   = '0;
      have_ref_d = 1'b0;
      to_fired_d = 1'b0;
    end else begin
      if (edge_d) begin
        hp_cnt_d   = CNT_W'(1);
        to_fired_d = 1'b0;
        have_ref_d = 1'b1;
        if (have_ref_q) begin
          pv_d   = 1'b1;
          half_d = hp_cnt_q;
        end
      end else begin
        if (hp_cnt_q != HP_SAT) hp_cnt_d = hp_cnt_q + CNT_W'(1);
        if (timeout) begin
          to_fired_d = 1'b1;
          have_ref_d = 1'b0;
        end
      end
      // Entering LOST discards the reference so the exit edge starts afresh.
      if (go_lost) have_ref_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hp_cnt_q   <= '0;
      half_q     <= '0;
      pv_q       <= 1'b0;
      have_ref_q <= 1'b0;
      to_fired_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], scaled_clk_in};
      prev_q     <= sync_lvl;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hp_cnt_q   <= hp_cnt_d;
      half_q     <= half_d;
      pv_q       <= pv_d;
      have_ref_q <= have_ref_d;
      to_fired_q <= to_fired_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
      lost_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lost_q  <= lost_d;
      err_q   <= err_d;
    end
  end

  // FSM next state: reacts to the registered measurement, so status lags the strobe by one edge.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    lost_d  = lost_q;
    err_d   = err_q;
    go_lost = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      good_d  = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
        ST_ACQUIRE: begin
          if (timeout || (pv_q && !in_range)) begin
            good_d = '0;
          end else if (pv_q) begin
            if (good_q + GOOD_W'(1) == GOOD_LOCK) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (timeout || (pv_q && !in_range)) begin
            state_d = ST_LOST;
            lost_d  = 1'b1;
            go_lost = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end
        ST_LOST: begin
          if (edge_q) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; state_o exposes the state for debug and checkers.
  always_comb begin
    locked  = (state_q == ST_LOCKED);
    state_o = state_q;
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign lost         = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_scaled_clk_monitor.sv
// Directed bench for scaled_clk_monitor: a vector table of half-periods with
// expected status, plus hand sequences for timeout, enable, reset and saturation.
module tb_scaled_clk_monitor;

  logic       clk;
  logic       reset;
  logic       scaled_clk_in;
  logic       enable;
  logic       rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [8:0] half_period;
  logic [7:0] err_count;
  logic [1:0] state_o;

  // Second instance with a short expected half so saturation runs quickly.
  logic       sat_in, sat_en;
  logic       s_rise, s_fall, s_pv, s_locked, s_lost;
  logic [8:0] s_hp;
  logic [7:0] s_err;
  logic [1:0] s_state;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int gap;
    bit pv;
    int hp;
    bit lk;
    bit ls;
    int err;
    int st;
  } vec_t;

  vec_t tab[$];
  int   vi = 0;

  scaled_clk_monitor u_dut (
    .clk(clk), .reset(reset), .scaled_clk_in(scaled_clk_in), .enable(enable),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
    .period_valid(period_valid), .locked(locked), .lost(lost),
    .err_count(err_count), .state_o(state_o)
  );

  scaled_clk_monitor #(.EXP_HALF(12)) u_sat (
    .clk(clk), .reset(reset), .scaled_clk_in(sat_in), .enable(sat_en),
    .rise_pulse(s_rise), .fall_pulse(s_fall), .half_period(s_hp),
    .period_valid(s_pv), .locked(s_locked), .lost(s_lost),
    .err_count(s_err), .state_o(s_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int gap, bit pv, int hp, bit lk, bit ls, int err, int st);
    vec_t v;
    v.gap = gap; v.pv = pv; v.hp = hp; v.lk = lk; v.ls = ls; v.err = err; v.st = st;
    return v;
  endfunction

  // Entered 4 negedges after the previous toggle; toggles 'gap' cycles after it.
  task automatic run_vecs(input int n);
    vec_t  v;
    string t;
    for (int k = 0; k < n; k++) begin
      v = tab[vi];
      t = $sformatf("v%0d", vi);
      repeat (v.gap - 4) @(negedge clk);
      scaled_clk_in = ~scaled_clk_in;
      repeat (3) @(negedge clk);
      check({t, "_rise"}, int'(rise_pulse), int'(scaled_clk_in));
      check({t, "_fall"}, int'(fall_pulse), int'(!scaled_clk_in));
      check({t, "_pv"}, int'(period_valid), int'(v.pv));
      if (v.pv) check({t, "_hp"}, int'(half_period), v.hp);
      @(negedge clk);
      check({t, "_locked"}, int'(locked), int'(v.lk));
      check({t, "_lost"}, int'(lost), int'(v.ls));
      check({t, "_err"}, int'(err_count), v.err);
      check({t, "_state"}, int'(state_o), v.st);
      vi++;
    end
  endtask

  task automatic sat_half(input int n);
    repeat (n) @(negedge clk);
    sat_in = ~sat_in;
  endtask

  initial begin
    // Phase A: lock at 101, tolerance in LOCKED, 90-half loss, ACQUIRE boundaries, timeout.
    tab.push_back(mk(10, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 0, 0, 1));
    tab.push_back(mk(101, 1, 101, 1, 0, 0, 2));
    tab.push_back(mk(103, 1, 103, 1, 0, 0, 2));
    tab.push_back(mk(99,  1, 99,  1, 0, 0, 2));
    tab.push_back(mk(90,  1, 90,  0, 1, 1, 3));
    tab.push_back(mk(101, 0, 0,   0, 1, 1, 1));
    tab.push_back(mk(99,  1, 99,  0, 1, 1, 1));
    tab.push_back(mk(103, 1, 103, 0, 1, 1, 1));
    tab.push_back(mk(101, 1, 101, 0, 1, 1, 1));
    tab.push_back(mk(98,  1, 98,  0, 1, 1, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 1, 1, 1));
    tab.push_back(mk(104, 1, 104, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 1, 1, 1));
    tab.push_back(mk(105, 0, 0,   0, 1, 1, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 1, 1, 1));
    tab.push_back(mk(101, 1, 101, 1, 1, 1, 2));
    // Phase B: recovery from the frozen-input loss.
    tab.push_back(mk(10, 0, 0, 0, 1, 2, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 1, 2, 1));
    tab.push_back(mk(101, 1, 101, 1, 1, 2, 2));
    // Phase C: re-acquire after enable drop.
    tab.push_back(mk(10, 0, 0, 0, 0, 2, 1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(101, 1, 101, 0, 0, 2, 1));
    tab.push_back(mk(101, 1, 101, 1, 0, 2, 2));
    // Phase D: first measurement after reset.
    tab.push_back(mk(101, 1, 101, 0, 0, 0, 1));

    reset = 1'b0; enable = 1'b0; scaled_clk_in = 1'b0; sat_in = 1'b0; sat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", int'(locked), 0);
    check("rst_lost", int'(lost), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_pv", int'(period_valid), 0);
    check("rst_hp", int'(half_period), 0);
    check("rst_rise", int'(rise_pulse), 0);
    check("rst_fall", int'(fall_pulse), 0);
    check("rst_state", int'(state_o), 0);

    reset = 1'b1; enable = 1'b1;
    repeat (5) @(negedge clk);
    check("en_state", int'(state_o), 1);

    run_vecs(25);

    // Input frozen while LOCKED: timeout decides 104 cycles after the last strobe.
    repeat (102) @(negedge clk);
    check("frz_pre_locked", int'(locked), 1);
    @(negedge clk);
    check("frz_locked", int'(locked), 0);
    check("frz_lost", int'(lost), 1);
    check("frz_err", int'(err_count), 2);
    check("frz_state", int'(state_o), 3);
    repeat (300) @(negedge clk);
    check("frz_hold_err", int'(err_count), 2);
    check("frz_hold_state", int'(state_o), 3);

    run_vecs(5);

    // enable dropped while LOCKED.
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_locked", int'(locked), 0);
    check("dis_lost", int'(lost), 0);
    check("dis_pv", int'(period_valid), 0);
    check("dis_err", int'(err_count), 2);
    check("dis_state", int'(state_o), 0);
    enable = 1'b1;

    run_vecs(5);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_lost", int'(lost), 0);
    check("arst_err", int'(err_count), 0);
    check("arst_hp", int'(half_period), 0);
    check("arst_state", int'(state_o), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // Input is high here, so the cleared synchroniser sees a rise as the first edge.
    repeat (3) @(negedge clk);
    check("arst_first_rise", int'(rise_pulse), int'(scaled_clk_in));
    check("arst_first_pv", int'(period_valid), 0);
    @(negedge clk);
    run_vecs(1);

    // Saturation: 300 lock/loss cycles on the short-ratio instance.
    sat_en = 1'b1;
    repeat (3) @(negedge clk);
    sat_in = ~sat_in;
    for (int i = 0; i < 4; i++) sat_half(12);
    for (int it = 0; it < 300; it++) begin
      sat_half(6);
      repeat (5) @(negedge clk);
      check($sformatf("sat%0d_err", it), int'(s_err), (it + 1 > 255) ? 255 : it + 1);
      check($sformatf("sat%0d_hp", it), int'(s_hp), 6);
      check($sformatf("sat%0d_lost", it), int'(s_lost), 1);
      check($sformatf("sat%0d_locked", it), int'(s_locked), 0);
      sat_half(7);
      for (int j = 0; j < 4; j++) sat_half(12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
